// File: rtl/serial_negate_ctrl_if.sv
// Handshake bundle between the serial_negate_ctrl sequencer and its producer/consumer.
// The master side supplies words and accepts results; the slave side is the sequencer.
interface serial_negate_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ovf;
  logic             out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ovf, out_err
  );
endinterface

// File: rtl/serial_negate_ctrl.sv
// Sequencer around a bit-serial two's-complement converter: accepts a word,
// clears the converter, shifts the word out LSB-first, gathers the serial
// result back into a word and cross-checks it against a locally computed negation.
module serial_negate_ctrl #(
  parameter int WIDTH = 8,
  parameter int Y_LAT = 1
) (
  input  logic                t_clk,
  input  logic                r,
  serial_negate_ctrl_if.slave bus,
  output logic                conv_i,
  output logic                conv_r,
  input  logic                conv_y,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  // Counter covers both the SHIFT bit index and the short DRAIN count.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'((Y_LAT > 0) ? (Y_LAT - 1) : 0);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] sr_reg;
  logic [WIDTH-1:0] exp_reg;
  logic [WIDTH-1:0] coll_reg, coll_next;
  logic [WIDTH-1:0] data_reg;
  logic             zero_reg, ovf_reg, err_reg;
  logic             accept;
  logic             drive;
  logic             qual;
  logic             load;

  assign accept = bus.in_valid && (state_reg == IDLE);
  assign drive  = (state_reg == SHIFT);

  // The last qualified sample lands on the same edge that enters DONE,
  // so the output word is taken from the post-shift collection value.
  assign load = (state_reg != DONE) && (state_next == DONE);

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_data  = data_reg;
  assign bus.out_zero  = zero_reg;
  assign bus.out_ovf   = ovf_reg;
  assign bus.out_err   = err_reg;
  assign busy          = (state_reg != IDLE);
  assign conv_r        = (state_reg == IDLE) || (state_reg == CLR);
  assign conv_i        = drive && sr_reg[0];

  // State and bit counter register.
  always_ff @(posedge t_clk) begin
    if (!r) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: CLR for one cycle, WIDTH shift cycles, Y_LAT drain cycles, then hold in DONE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = CLR;
          cnt_next   = '0;
        end
      end
      CLR: begin
        state_next = SHIFT;
        cnt_next   = '0;
      end
      SHIFT: begin
        if (cnt_reg == LAST_BIT) begin
          cnt_next   = '0;
          state_next = (Y_LAT > 0) ? DRAIN : DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_reg == LAST_DRAIN) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The "bit driven" strobe is delayed by the converter latency so that
  // conv_y is sampled only when it carries a result bit for this word.
  generate
    if (Y_LAT == 0) begin : g_no_delay
      assign qual = drive;
    end else begin : g_delay
      logic [Y_LAT-1:0] dly_reg;

      // Strobe delay line, flushed by reset so an aborted word leaves no stray samples.
      always_ff @(posedge t_clk) begin
        if (!r) begin
          dly_reg <= '0;
        end else begin
          dly_reg[0] <= drive;
          for (int k = 1; k < Y_LAT; k++) dly_reg[k] <= dly_reg[k-1];
        end
      end

      assign qual = dly_reg[Y_LAT-1];
    end
  endgenerate

  // Result bits arrive LSB-first, so each enters at the MSB and moves right.
  assign coll_next = qual ? {conv_y, coll_reg[WIDTH-1:1]} : coll_reg;

  // Datapath: latch the word and its expected negation, shift it out, capture the result.
  always_ff @(posedge t_clk) begin
    if (!r) begin
      sr_reg   <= '0;
      exp_reg  <= '0;
      coll_reg <= '0;
      data_reg <= '0;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      coll_reg <= coll_next;
      if (accept) begin
        sr_reg   <= bus.in_data;
        exp_reg  <= ~bus.in_data + 1'b1;
        zero_reg <= (bus.in_data == '0);
        ovf_reg  <= (bus.in_data == MIN_VAL);
        coll_reg <= '0;
      end else if (drive) begin
        sr_reg <= sr_reg >> 1;
      end
      if (load) begin
        data_reg <= coll_next;
        err_reg  <= (coll_next != exp_reg);
      end
    end
  end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Bench for serial_negate_ctrl: three instances with Y_LAT = 0, 1, 2, each
// paired with a behavioural serial two's-complement converter model.
module tb_serial_negate_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] iv, ordy, fault;
  logic [7:0] id [3];
  wire  [2:0] ir, ov, oz, oo, oe, ci, cr, bz;
  wire  [7:0] od [3];

  int checks = 0;
  int errors = 0;

  // Instance gi uses Y_LAT = gi.
  for (genvar gi = 0; gi < 3; gi++) begin : g_u
    serial_negate_ctrl_if #(.WIDTH(8)) bus ();
    logic cy, flag, raw, d1, d2;
    int   pos;

    assign bus.in_valid  = iv[gi];
    assign bus.in_data   = id[gi];
    assign bus.out_ready = ordy[gi];
    assign ir[gi] = bus.in_ready;
    assign ov[gi] = bus.out_valid;
    assign od[gi] = bus.out_data;
    assign oz[gi] = bus.out_zero;
    assign oo[gi] = bus.out_ovf;
    assign oe[gi] = bus.out_err;

    serial_negate_ctrl #(.WIDTH(8), .Y_LAT(gi)) dut (
      .t_clk (clk),
      .r     (rst_n),
      .bus   (bus),
      .conv_i(ci[gi]),
      .conv_r(cr[gi]),
      .conv_y(cy),
      .busy  (bz[gi])
    );

    // Converter model: output is input XOR "a 1 has already been seen"; optional fault on bit 0.
    always_ff @(posedge clk) begin
      if (cr[gi]) begin
        flag <= 1'b0;
        pos  <= 0;
      end else begin
        flag <= flag | ci[gi];
        pos  <= pos + 1;
      end
    end
    assign raw = (fault[gi] && !cr[gi] && pos == 0) ? 1'b0 : (ci[gi] ^ flag);
    always_ff @(posedge clk) begin
      d1 <= raw;
      d2 <= d1;
    end
    assign cy = (gi == 0) ? raw : ((gi == 1) ? d1 : d2);
  end

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       z;
    logic       o;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic accept(input int u, input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    while (!ir[u] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", {31'd0, ir[u]}, 32'd1);
    iv[u] = 1'b1;
    id[u] = d;
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    id[u] = 8'($urandom);
  endtask

  // Counts cycles after the accept edge until out_valid; records conv_i during SHIFT.
  task automatic collect(input int u, output int lat, output logic [7:0] bits);
    lat  = -1;
    bits = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 9) bits[c-2] = ci[u];
      if (ov[u]) begin
        lat = c;
        break;
      end
    end
    $display("word unit=%0d out=%02h zero=%0b ovf=%0b err=%0b latency=%0d",
             u, od[u], oz[u], oo[u], oe[u], lat);
  endtask

  task automatic finish_word(input int u);
    @(posedge clk);
    #1;
    chk("hs_out_valid_drop", {31'd0, ov[u]}, 32'd0);
    chk("hs_in_ready_rise", {31'd0, ir[u]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] bits;

    vecs[0] = '{8'h05, 8'hFB, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 8'hC4, 1'b0, 1'b0};

    iv = '0; ordy = '1; fault = '0; rst_n = 1'b0;
    for (int k = 0; k < 3; k++) id[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", {31'd0, ir[1]}, 32'd1);
    chk("rst_out_valid", {31'd0, ov[1]}, 32'd0);
    chk("rst_out_data", {24'd0, od[1]}, 32'd0);
    chk("rst_flags", {29'd0, oz[1], oo[1], oe[1]}, 32'd0);
    chk("rst_conv_i", {31'd0, ci[1]}, 32'd0);
    chk("rst_conv_r", {31'd0, cr[1]}, 32'd1);
    chk("rst_busy", {31'd0, bz[1]}, 32'd0);

    // Table-driven words on the Y_LAT=1 instance.
    for (int v = 0; v < 6; v++) begin
      accept(1, vecs[v].din);
      collect(1, lat, bits);
      chk("vec_conv_i_seq", {24'd0, bits}, {24'd0, vecs[v].din});
      chk("vec_latency", lat, 32'd11);
      chk("vec_out_data", {24'd0, od[1]}, {24'd0, vecs[v].dout});
      chk("vec_out_zero", {31'd0, oz[1]}, {31'd0, vecs[v].z});
      chk("vec_out_ovf", {31'd0, oo[1]}, {31'd0, vecs[v].o});
      chk("vec_out_err", {31'd0, oe[1]}, 32'd0);
      finish_word(1);
    end

    // Backpressure: result held for 20 cycles, new word offered meanwhile.
    ordy[1] = 1'b0;
    accept(1, 8'h7F);
    collect(1, lat, bits);
    chk("bp_latency", lat, 32'd11);
    for (int k = 0; k < 20; k++) begin
      iv[1] = 1'b1;
      id[1] = 8'h11;
      @(negedge clk);
      chk("bp_out_valid", {31'd0, ov[1]}, 32'd1);
      chk("bp_out_data", {24'd0, od[1]}, 32'h81);
      chk("bp_in_ready", {31'd0, ir[1]}, 32'd0);
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    finish_word(1);
    accept(1, 8'h11);
    collect(1, lat, bits);
    chk("bp_next_data", {24'd0, od[1]}, 32'hEF);
    finish_word(1);

    // Reset during SHIFT cycle 3 of word 0x5A.
    accept(1, 8'h5A);
    repeat (5) @(negedge clk);
    chk("mid_busy", {31'd0, bz[1]}, 32'd1);
    chk("mid_conv_r", {31'd0, cr[1]}, 32'd0);
    chk("mid_conv_i_bit3", {31'd0, ci[1]}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_conv_r", {31'd0, cr[1]}, 32'd1);
    chk("mid_rst_busy", {31'd0, bz[1]}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, ov[1]}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, ir[1]}, 32'd1);
    chk("mid_rst_out_data", {24'd0, od[1]}, 32'd0);
    accept(1, 8'h05);
    collect(1, lat, bits);
    chk("mid_after_data", {24'd0, od[1]}, 32'hFB);
    chk("mid_after_err", {31'd0, oe[1]}, 32'd0);
    finish_word(1);

    // Converter fault: result bit 0 forced low.
    fault[1] = 1'b1;
    accept(1, 8'h05);
    collect(1, lat, bits);
    chk("fault_out_data", {24'd0, od[1]}, 32'hFA);
    chk("fault_out_err", {31'd0, oe[1]}, 32'd1);
    finish_word(1);
    fault[1] = 1'b0;

    // Latency sweep on the Y_LAT=0 and Y_LAT=2 instances.
    for (int u = 0; u < 3; u += 2) begin
      accept(u, 8'h3C);
      collect(u, lat, bits);
      chk("sweep_latency", lat, (u == 0) ? 32'd10 : 32'd12);
      chk("sweep_conv_i_seq", {24'd0, bits}, 32'h3C);
      chk("sweep_out_data", {24'd0, od[u]}, 32'hC4);
      chk("sweep_out_err", {31'd0, oe[u]}, 32'd0);
      finish_word(u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
